led_sequencer: RTL and testbench
================================

LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter WIDTH, default 12, SHALL set the bit width of the half-period configuration and internal timer.
REQ-002 Port i_clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-003 Port i_reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 Port i_cfg_valid  input  1  SHALL indicate a configuration word is offered.
REQ-005 Port o_cfg_ready  output  1  SHALL indicate the block accepts a configuration this cycle.
REQ-006 Port i_cfg_mode  input  2  SHALL select the mode: 0 OFF, 1 ON, 2 BLINK (continuous), 3 BURST.
REQ-007 Port i_cfg_count  input  4  SHALL give the number of blinks for BURST; ignored in other modes.
REQ-008 Port i_cfg_half  input  WIDTH  SHALL give the half-period in clock cycles; 0 treated as 1.
REQ-009 Port o_led  output  1  SHALL be the registered LED drive.
REQ-010 Port o_busy  output  1  SHALL be high while a BURST is in progress.
REQ-011 Port o_done  output  1  SHALL pulse high for exactly one cycle when a BURST completes.

Function
REQ-012 States SHALL be IDLE (led 0), SOLID (led 1), HIGH (led 1, timing), LOW (led 0, timing).
REQ-013 Accept SHALL occur on a rising edge with i_cfg_valid=1 and o_cfg_ready=1; mode, count, and half are captured at that edge.
REQ-014 o_cfg_ready SHALL be 1 in IDLE and SOLID, and in HIGH/LOW when the active mode is BLINK; it SHALL be 0 during a BURST.
REQ-015 On accept, mode 0 SHALL go to IDLE and mode 1 SHALL go to SOLID; modes 2 and 3 with count>0 SHALL go to HIGH with the timer loaded to half-1.
REQ-016 o_led SHALL reflect the new state from the accepting edge, so there is zero cycles of added latency beyond the register.
REQ-017 The timer SHALL decrement each cycle in HIGH/LOW; at 0 it SHALL reload half-1 and toggle HIGH<->LOW, giving exactly half cycles per phase.
REQ-018 The blink counter SHALL decrement at each LOW->HIGH transition, and only in BURST.
REQ-019 In BURST, when the timer reaches 0 in LOW with the blink counter at 1, the block SHALL go to IDLE, pulse o_done on that edge, drop o_busy, and raise o_cfg_ready.
REQ-020 A BURST SHALL last exactly 2*count*max(half,1) cycles with o_busy=1.
REQ-021 A BURST accept with count=0 SHALL stay IDLE, keep o_led=0, keep o_busy=0, and pulse o_done on the accepting edge.
REQ-022 A re-accept during BLINK SHALL restart at HIGH with a fresh timer; any partial phase SHALL be discarded.
REQ-023 Configuration on i_cfg_* while o_cfg_ready=0 SHALL be ignored, not queued.
REQ-024 The timer SHALL be WIDTH bits; half=2^WIDTH-1 SHALL work without overflow, and half=0 or 1 SHALL give 1-cycle phases.

Reset
REQ-025 When i_reset is asserted, the block SHALL immediately enter IDLE with o_led=0, o_busy=0, o_done=0, o_cfg_ready=1, and timer and counter cleared.
REQ-026 A reset asserted mid-BURST SHALL abort it without pulsing o_done; after release, the block SHALL wait for a new configuration.

Verification
REQ-027 Reset, then accept mode 3, count 3, half 4 -> o_led pattern 1111 0000 x3; o_busy high 24 cycles; o_done single pulse on the 24th edge; ready low throughout.
REQ-028 Accept mode 2, half 2, then after 5 cycles accept mode 2, half 3 -> the pattern restarts at HIGH and 3-cycle phases follow.
REQ-029 Accept mode 3, count 0 -> o_done one-cycle pulse at accept, o_led stays 0, o_busy stays 0.
REQ-030 During BURST (count 2, half 5), assert i_cfg_valid with mode 1 -> ignored; the burst completes in 20 cycles and ends IDLE, not SOLID.
REQ-031 Accept mode 3, count 4, half 3, then assert i_reset asynchronously at cycle 7 -> o_led and o_busy drop before the next clock edge; no o_done pulse.
REQ-032 Accept mode 2 with half 0, then half 1 -> o_led toggles every cycle in both cases; accept mode 1 -> o_led steady at 1.

Source files
------------

// File: rtl/led_sequencer.sv
// LED sequencer: drives one LED as OFF, ON, continuous BLINK or a counted BURST of blinks.
// Latency: o_led, o_busy and o_done are registered and reflect the configuration from the accepting edge.
// Backpressure: o_cfg_ready is low only while a BURST runs; configuration offered then is dropped, not queued.
//
// Ports:
//   i_clk, i_reset               clock, asynchronous active-high reset
//   i_cfg_valid / o_cfg_ready    configuration handshake
//   i_cfg_mode                   0 OFF, 1 ON, 2 BLINK, 3 BURST
//   i_cfg_count                  number of blinks in BURST mode
//   i_cfg_half                   half-period in cycles (0 behaves as 1)
//   o_led, o_busy, o_done        LED drive, burst in progress, one-cycle burst-complete pulse
module led_sequencer #(
  parameter int WIDTH = 12
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [1:0]       i_cfg_mode,
  input  logic [3:0]       i_cfg_count,
  input  logic [WIDTH-1:0] i_cfg_half,
  output logic             o_led,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOLID = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]       CNT_ONE = 4'd1;

  state_t           state;
  logic [WIDTH-1:0] timer;
  logic [WIDTH-1:0] reload;      // half-1, stored so every phase reload uses the accepted value
  logic [3:0]       blinks;      // blinks remaining, including the one in progress
  logic             burst;       // active blink sequence is a counted BURST
  logic             accept;
  logic [WIDTH-1:0] cfg_reload;

  assign accept = i_cfg_valid && o_cfg_ready;

  // A half-period of 0 is treated as 1, so both map to a reload value of 0.
  assign cfg_reload = (i_cfg_half == '0) ? '0 : (i_cfg_half - ONE);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      timer       <= '0;
      reload      <= '0;
      blinks      <= '0;
      burst       <= 1'b0;
      o_led       <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_cfg_ready <= 1'b1;
    end else begin
      o_done <= 1'b0;
      if (accept) begin
        case (i_cfg_mode)
          2'd0: begin
            state       <= ST_IDLE;
            o_led       <= 1'b0;
            o_busy      <= 1'b0;
            o_cfg_ready <= 1'b1;
            burst       <= 1'b0;
          end
          2'd1: begin
            state       <= ST_SOLID;
            o_led       <= 1'b1;
            o_busy      <= 1'b0;
            o_cfg_ready <= 1'b1;
            burst       <= 1'b0;
          end
          2'd2: begin
            // A re-accept during BLINK lands here too and discards the partial phase.
            state       <= ST_HIGH;
            timer       <= cfg_reload;
            reload      <= cfg_reload;
            o_led       <= 1'b1;
            o_busy      <= 1'b0;
            o_cfg_ready <= 1'b1;
            burst       <= 1'b0;
          end
          default: begin
            if (i_cfg_count == 4'd0) begin
              // Empty burst completes immediately without lighting the LED.
              state       <= ST_IDLE;
              o_led       <= 1'b0;
              o_busy      <= 1'b0;
              o_done      <= 1'b1;
              o_cfg_ready <= 1'b1;
              burst       <= 1'b0;
            end else begin
              state       <= ST_HIGH;
              timer       <= cfg_reload;
              reload      <= cfg_reload;
              blinks      <= i_cfg_count;
              o_led       <= 1'b1;
              o_busy      <= 1'b1;
              o_cfg_ready <= 1'b0;
              burst       <= 1'b1;
            end
          end
        endcase
      end else if (state == ST_HIGH || state == ST_LOW) begin
        if (timer != '0) begin
          timer <= timer - ONE;
        end else begin
          timer <= reload;
          if (state == ST_HIGH) begin
            state <= ST_LOW;
            o_led <= 1'b0;
          end else if (burst && blinks == CNT_ONE) begin
            // End of the last LOW phase: burst complete.
            state       <= ST_IDLE;
            o_led       <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
            o_cfg_ready <= 1'b1;
            burst       <= 1'b0;
            blinks      <= '0;
          end else begin
            state <= ST_HIGH;
            o_led <= 1'b1;
            if (burst) begin
              blinks <= blinks - CNT_ONE;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

  localparam int W = 12;

  logic         i_clk;
  logic         i_reset;
  logic         i_cfg_valid;
  logic         o_cfg_ready;
  logic [1:0]   i_cfg_mode;
  logic [3:0]   i_cfg_count;
  logic [W-1:0] i_cfg_half;
  logic         o_led;
  logic         o_busy;
  logic         o_done;

  int n_checks = 0;
  int n_errors = 0;

  led_sequencer #(.WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_mode  (i_cfg_mode),
    .i_cfg_count (i_cfg_count),
    .i_cfg_half  (i_cfg_half),
    .o_led       (o_led),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] mode, input logic [3:0] cnt, input logic [W-1:0] half);
    i_cfg_valid = 1'b1;
    i_cfg_mode  = mode;
    i_cfg_count = cnt;
    i_cfg_half  = half;
  endtask

  // Accept a configuration at the next edge; returns sampled just after it.
  task automatic accept(input logic [1:0] mode, input logic [3:0] cnt, input logic [W-1:0] half);
    offer(mode, cnt, half);
    tick();
    i_cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({o_led, o_busy, o_done, o_cfg_ready} !== 4'b0001) begin
      n_errors++;
      $display("FAIL reset_state: led/busy/done/ready=%b expected 0001", {o_led, o_busy, o_done, o_cfg_ready});
    end
    #3 i_reset = 1'b0;
    tick();
    n_checks++;
    if ({o_led, o_busy, o_done, o_cfg_ready} !== 4'b0001) begin
      n_errors++;
      $display("FAIL reset_release: led/busy/done/ready=%b expected 0001", {o_led, o_busy, o_done, o_cfg_ready});
    end
  endtask

  // Burst of 3 blinks, half 4: 1111 0000 x3, busy for 24 cycles, done on the 24th edge.
  task automatic test_burst();
    logic exp_led;
    accept(2'd3, 4'd3, 12'd4);
    for (int k = 0; k < 24; k++) begin
      exp_led = ((k / 4) % 2) == 0;
      n_checks++;
      if ({o_led, o_busy, o_done, o_cfg_ready} !== {exp_led, 3'b100}) begin
        n_errors++;
        $display("FAIL burst_cycle%0d: led/busy/done/ready=%b expected %b", k,
                 {o_led, o_busy, o_done, o_cfg_ready}, {exp_led, 3'b100});
      end
      tick();
    end
    n_checks++;
    if ({o_led, o_busy, o_done, o_cfg_ready} !== 4'b0011) begin
      n_errors++;
      $display("FAIL burst_end: led/busy/done/ready=%b expected 0011", {o_led, o_busy, o_done, o_cfg_ready});
    end
    tick();
    n_checks++;
    if ({o_led, o_done} !== 2'b00) begin
      n_errors++;
      $display("FAIL burst_done_pulse: led/done=%b expected 00", {o_led, o_done});
    end
  endtask

  // Blink half 2, then re-accept half 3 after 5 cycles: restart at HIGH.
  task automatic test_restart();
    logic exp_led;
    accept(2'd2, 4'd0, 12'd2);
    for (int k = 0; k < 5; k++) begin
      exp_led = ((k / 2) % 2) == 0;
      n_checks++;
      if (o_led !== exp_led || o_cfg_ready !== 1'b1 || o_busy !== 1'b0) begin
        n_errors++;
        $display("FAIL blink2_cycle%0d: led=%b ready=%b busy=%b expected led=%b ready=1 busy=0",
                 k, o_led, o_cfg_ready, o_busy, exp_led);
      end
      if (k < 4) tick();
    end
    accept(2'd2, 4'd0, 12'd3);
    for (int k = 0; k < 9; k++) begin
      exp_led = ((k / 3) % 2) == 0;
      n_checks++;
      if (o_led !== exp_led) begin
        n_errors++;
        $display("FAIL restart_cycle%0d: led=%b expected %b", k, o_led, exp_led);
      end
      tick();
    end
    accept(2'd0, 4'd0, 12'd0);
    n_checks++;
    if (o_led !== 1'b0) begin
      n_errors++;
      $display("FAIL restart_off: led=%b expected 0", o_led);
    end
  endtask

  task automatic test_count_zero();
    accept(2'd3, 4'd0, 12'd5);
    n_checks++;
    if ({o_led, o_busy, o_done, o_cfg_ready} !== 4'b0011) begin
      n_errors++;
      $display("FAIL count0_accept: led/busy/done/ready=%b expected 0011", {o_led, o_busy, o_done, o_cfg_ready});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({o_led, o_busy, o_done} !== 3'b000) begin
        n_errors++;
        $display("FAIL count0_after%0d: led/busy/done=%b expected 000", k, {o_led, o_busy, o_done});
      end
    end
  endtask

  // Mode-1 request during a burst is dropped; burst ends IDLE after 20 cycles.
  task automatic test_ignore();
    logic exp_led;
    accept(2'd3, 4'd2, 12'd5);
    for (int k = 0; k < 20; k++) begin
      if (k == 3) offer(2'd1, 4'd0, 12'd1);
      if (k == 11) i_cfg_valid = 1'b0;
      exp_led = ((k / 5) % 2) == 0;
      n_checks++;
      if ({o_led, o_busy, o_done, o_cfg_ready} !== {exp_led, 3'b100}) begin
        n_errors++;
        $display("FAIL ignore_cycle%0d: led/busy/done/ready=%b expected %b", k,
                 {o_led, o_busy, o_done, o_cfg_ready}, {exp_led, 3'b100});
      end
      tick();
    end
    n_checks++;
    if ({o_led, o_busy, o_done, o_cfg_ready} !== 4'b0011) begin
      n_errors++;
      $display("FAIL ignore_end: led/busy/done/ready=%b expected 0011", {o_led, o_busy, o_done, o_cfg_ready});
    end
    tick();
    n_checks++;
    if ({o_led, o_done} !== 2'b00) begin
      n_errors++;
      $display("FAIL ignore_not_solid: led/done=%b expected 00", {o_led, o_done});
    end
  endtask

  // Asynchronous reset mid-burst: outputs drop before the next edge, no done pulse.
  task automatic test_reset_mid();
    logic exp_led;
    accept(2'd3, 4'd4, 12'd3);
    for (int k = 0; k < 7; k++) begin
      exp_led = ((k / 3) % 2) == 0;
      n_checks++;
      if ({o_led, o_busy} !== {exp_led, 1'b1}) begin
        n_errors++;
        $display("FAIL rstmid_cycle%0d: led/busy=%b expected %b", k, {o_led, o_busy}, {exp_led, 1'b1});
      end
      if (k < 6) tick();
    end
    #2 i_reset = 1'b1;
    #1;
    n_checks++;
    if ({o_led, o_busy, o_done, o_cfg_ready} !== 4'b0001) begin
      n_errors++;
      $display("FAIL rstmid_async: led/busy/done/ready=%b expected 0001", {o_led, o_busy, o_done, o_cfg_ready});
    end
    tick();
    tick();
    #3 i_reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_checks++;
      if ({o_led, o_busy, o_done, o_cfg_ready} !== 4'b0001) begin
        n_errors++;
        $display("FAIL rstmid_after%0d: led/busy/done/ready=%b expected 0001", k,
                 {o_led, o_busy, o_done, o_cfg_ready});
      end
    end
  endtask

  // Half 0 and half 1 both toggle every cycle; mode 1 holds the LED on.
  task automatic test_fast();
    logic exp_led;
    accept(2'd2, 4'd0, 12'd0);
    for (int k = 0; k < 6; k++) begin
      exp_led = (k % 2) == 0;
      n_checks++;
      if (o_led !== exp_led) begin
        n_errors++;
        $display("FAIL half0_cycle%0d: led=%b expected %b", k, o_led, exp_led);
      end
      if (k < 5) tick();
    end
    accept(2'd2, 4'd0, 12'd1);
    for (int k = 0; k < 6; k++) begin
      exp_led = (k % 2) == 0;
      n_checks++;
      if (o_led !== exp_led) begin
        n_errors++;
        $display("FAIL half1_cycle%0d: led=%b expected %b", k, o_led, exp_led);
      end
      if (k < 5) tick();
    end
    accept(2'd1, 4'd0, 12'd1);
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if ({o_led, o_busy, o_cfg_ready} !== 3'b101) begin
        n_errors++;
        $display("FAIL solid_cycle%0d: led/busy/ready=%b expected 101", k, {o_led, o_busy, o_cfg_ready});
      end
      tick();
    end
    accept(2'd0, 4'd0, 12'd0);
    n_checks++;
    if (o_led !== 1'b0) begin
      n_errors++;
      $display("FAIL solid_off: led=%b expected 0", o_led);
    end
  endtask

  // Largest half-period: 4095 cycles high, then low, no timer overflow.
  task automatic test_max_half();
    accept(2'd2, 4'd0, 12'hFFF);
    for (int k = 0; k < 4097; k++) begin
      if (k == 0 || k == 4094 || k == 4095 || k == 4096) begin
        n_checks++;
        if (o_led !== (k < 4095)) begin
          n_errors++;
          $display("FAIL maxhalf_cycle%0d: led=%b expected %b", k, o_led, (k < 4095));
        end
      end
      tick();
    end
    accept(2'd0, 4'd0, 12'd0);
  endtask

  // Shortest burst (1 blink, half 1) followed by a burst accepted on the done cycle.
  task automatic test_back_to_back();
    accept(2'd3, 4'd1, 12'd1);
    n_checks++;
    if ({o_led, o_busy, o_done} !== 3'b110) begin
      n_errors++;
      $display("FAIL b2b_first0: led/busy/done=%b expected 110", {o_led, o_busy, o_done});
    end
    tick();
    n_checks++;
    if ({o_led, o_busy, o_done} !== 3'b010) begin
      n_errors++;
      $display("FAIL b2b_first1: led/busy/done=%b expected 010", {o_led, o_busy, o_done});
    end
    tick();
    n_checks++;
    if ({o_led, o_busy, o_done, o_cfg_ready} !== 4'b0011) begin
      n_errors++;
      $display("FAIL b2b_first_end: led/busy/done/ready=%b expected 0011", {o_led, o_busy, o_done, o_cfg_ready});
    end
    accept(2'd3, 4'd1, 12'd2);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({o_led, o_busy, o_done} !== {(k < 2), 2'b10}) begin
        n_errors++;
        $display("FAIL b2b_second%0d: led/busy/done=%b expected %b", k,
                 {o_led, o_busy, o_done}, {(k < 2), 2'b10});
      end
      tick();
    end
    n_checks++;
    if ({o_led, o_busy, o_done} !== 3'b001) begin
      n_errors++;
      $display("FAIL b2b_second_end: led/busy/done=%b expected 001", {o_led, o_busy, o_done});
    end
  endtask

  initial begin
    i_reset     = 1'b1;
    i_cfg_valid = 1'b0;
    i_cfg_mode  = 2'd0;
    i_cfg_count = 4'd0;
    i_cfg_half  = '0;
    test_reset();
    test_burst();
    test_restart();
    test_count_zero();
    test_ignore();
    test_reset_mid();
    test_fast();
    test_max_half();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
